// File: rtl/ex_stage_if.sv
// EX/MEM pipeline register bundle: driven by the execute stage, consumed by the memory stage.
interface ex_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] alu_result_o;
    logic [XLEN-1:0] store_data_o;
    logic [4:0]      reg_waddr_o;
    logic            reg_wena_o;
    logic            mem2reg_o;
    logic            mem_rena_o;
    logic            mem_wena_o;
    logic [2:0]      funct3_o;

    modport master (
        output alu_result_o, store_data_o, reg_waddr_o, reg_wena_o,
               mem2reg_o, mem_rena_o, mem_wena_o, funct3_o
    );

    modport slave (
        input  alu_result_o, store_data_o, reg_waddr_o, reg_wena_o,
               mem2reg_o, mem_rena_o, mem_wena_o, funct3_o
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] curr_pc,
    input  logic [XLEN-1:0] reg1_data,
    input  logic [XLEN-1:0] reg2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      reg1_raddr,
    input  logic [4:0]      reg2_raddr,
    input  logic [4:0]      reg_waddr,
    input  logic            branch,
    input  logic            reg_wena,
    input  logic            mem2reg,
    input  logic            mem_rena,
    input  logic            mem_wena,
    input  logic [1:0]      aluop,
    input  logic            alusrc,
    input  logic [1:0]      jump,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    input  logic            wb_reg_wena,
    input  logic [4:0]      wb_reg_waddr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_stall,
    output logic            pipelineFlush,
    output logic [XLEN-1:0] target_pc,
    ex_stage_if.master      ex_mem
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] alu_q, store_q;
    logic [4:0]      waddr_q;
    logic            wena_q, m2r_q, rena_q, mwena_q;
    logic [2:0]      f3_q;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, ex_result, jalr_sum, link_pc;
    logic [4:0]      shamt;
    logic            is_jal, is_jalr, cond, taken;

    // EX/MEM beats MEM/WB; loads in EX/MEM are not yet resolved so they are skipped.
    always_comb begin
        op_a = reg1_data;
        if (reg_wena_o_hit(reg1_raddr))
            op_a = alu_q;
        else if (wb_reg_wena && wb_reg_waddr == reg1_raddr && reg1_raddr != 5'd0)
            op_a = wb_data;

        fwd_b = reg2_data;
        if (reg_wena_o_hit(reg2_raddr))
            fwd_b = alu_q;
        else if (wb_reg_wena && wb_reg_waddr == reg2_raddr && reg2_raddr != 5'd0)
            fwd_b = wb_data;
    end

    function automatic logic reg_wena_o_hit(input logic [4:0] raddr);
        return wena_q && !m2r_q && waddr_q == raddr && raddr != 5'd0;
    endfunction

    assign op_b  = alusrc ? imm : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        unique case (aluop)
            2'b00: alu_res = op_a + op_b;
            2'b11: alu_res = imm;
            2'b10: begin
                unique case (funct3)
                    3'b000: alu_res = (funct7 && !alusrc) ? op_a - op_b : op_a + op_b;
                    3'b001: alu_res = op_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b100: alu_res = op_a ^ op_b;
                    3'b101: alu_res = funct7 ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
                    3'b110: alu_res = op_a | op_b;
                    3'b111: alu_res = op_a & op_b;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000: cond = op_a == fwd_b;
            3'b001: cond = op_a != fwd_b;
            3'b100: cond = $signed(op_a) < $signed(fwd_b);
            3'b101: cond = $signed(op_a) >= $signed(fwd_b);
            3'b110: cond = op_a < fwd_b;
            3'b111: cond = op_a >= fwd_b;
            default: cond = 1'b0;
        endcase
    end

    assign is_jal    = jump == 2'b01;
    assign is_jalr   = jump == 2'b10;
    assign taken     = is_jal || is_jalr || (branch && cond);
    assign jalr_sum  = op_a + imm;
    assign link_pc   = curr_pc + PC_STEP;
    assign ex_result = (is_jal || is_jalr) ? link_pc : alu_res;

    always_comb begin
        target_pc = link_pc;
        if (is_jalr)
            target_pc = {jalr_sum[XLEN-1:1], 1'b0};
        else if (taken)
            target_pc = curr_pc + imm;
    end

    // A stalled transfer is re-evaluated on release, so only the released cycle flushes.
    assign pipelineFlush = rst && taken && !mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q   <= '0;
            store_q <= '0;
            waddr_q <= '0;
            wena_q  <= 1'b0;
            m2r_q   <= 1'b0;
            rena_q  <= 1'b0;
            mwena_q <= 1'b0;
            f3_q    <= '0;
        end else if (!mem_stall) begin
            alu_q   <= ex_result;
            store_q <= fwd_b;
            waddr_q <= reg_waddr;
            wena_q  <= reg_wena;
            m2r_q   <= mem2reg;
            rena_q  <= mem_rena;
            mwena_q <= mem_wena;
            f3_q    <= funct3;
        end
    end

    assign ex_mem.alu_result_o = alu_q;
    assign ex_mem.store_data_o = store_q;
    assign ex_mem.reg_waddr_o  = waddr_q;
    assign ex_mem.reg_wena_o   = wena_q;
    assign ex_mem.mem2reg_o    = m2r_q;
    assign ex_mem.mem_rena_o   = rena_q;
    assign ex_mem.mem_wena_o   = mwena_q;
    assign ex_mem.funct3_o     = f3_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] curr_pc, reg1_data, reg2_data, imm, wb_data;
    logic [4:0]  reg1_raddr, reg2_raddr, reg_waddr, wb_reg_waddr;
    logic        branch, reg_wena, mem2reg, mem_rena, mem_wena, alusrc, funct7;
    logic        wb_reg_wena, mem_stall;
    logic [1:0]  aluop, jump;
    logic [2:0]  funct3;
    logic        pipelineFlush;
    logic [31:0] target_pc;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage_if #(.XLEN(32)) exm ();

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .curr_pc(curr_pc), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .imm(imm), .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr), .reg_waddr(reg_waddr),
        .branch(branch), .reg_wena(reg_wena), .mem2reg(mem2reg), .mem_rena(mem_rena),
        .mem_wena(mem_wena), .aluop(aluop), .alusrc(alusrc), .jump(jump), .funct3(funct3),
        .funct7(funct7), .wb_reg_wena(wb_reg_wena), .wb_reg_waddr(wb_reg_waddr),
        .wb_data(wb_data), .mem_stall(mem_stall), .pipelineFlush(pipelineFlush),
        .target_pc(target_pc), .ex_mem(exm)
    );

    always #5 clk = ~clk;

    // Model of the EX/MEM contents as the memory stage should see them.
    logic [31:0] m_alu, m_store;
    logic [4:0]  m_waddr;
    logic        m_wena, m_m2r, m_rena, m_mwena;
    logic [2:0]  m_f3;

    typedef struct packed {
        logic        flush;
        logic [31:0] target;
        logic [31:0] result;
        logic [31:0] store;
    } exp_t;

    function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] id_val);
        if (ra == 5'd0) return id_val;
        if (m_wena && !m_m2r && m_waddr == ra) return m_alu;
        if (wb_reg_wena && wb_reg_waddr == ra) return wb_data;
        return id_val;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        logic [31:0] a, rs2, b, alu;
        int unsigned sa;
        logic br, jal, jalr;
        a   = fwd(reg1_raddr, reg1_data);
        rs2 = fwd(reg2_raddr, reg2_data);
        b   = alusrc ? imm : rs2;
        sa  = b % 32;
        alu = 32'd0;
        if (aluop == 2'b00) alu = a + b;
        else if (aluop == 2'b11) alu = imm;
        else if (aluop == 2'b10) begin
            case (funct3)
                3'd0: alu = (funct7 && !alusrc) ? a - b : a + b;
                3'd1: alu = a << sa;
                3'd2: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: alu = (a < b) ? 32'd1 : 32'd0;
                3'd4: alu = a ^ b;
                3'd5: alu = (funct7 && a[31]) ? ~((~a) >> sa) : a >> sa;
                3'd6: alu = a | b;
                default: alu = a & b;
            endcase
        end
        case (funct3)
            3'd0: br = a == rs2;
            3'd1: br = a != rs2;
            3'd4: br = $signed(a) < $signed(rs2);
            3'd5: br = !($signed(a) < $signed(rs2));
            3'd6: br = a < rs2;
            3'd7: br = !(a < rs2);
            default: br = 1'b0;
        endcase
        br   = br && branch;
        jal  = jump == 2'b01;
        jalr = jump == 2'b10;
        e.target = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (jal || br) ? curr_pc + imm : curr_pc + 32'd4;
        e.flush  = (jal || jalr || br) && !mem_stall && rst;
        e.result = (jal || jalr) ? curr_pc + 32'd4 : alu;
        e.store  = rs2;
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_alu <= 0; m_store <= 0; m_waddr <= 0; m_wena <= 0;
            m_m2r <= 0; m_rena <= 0; m_mwena <= 0; m_f3 <= 0;
        end else if (!mem_stall) begin
            m_alu   <= model_eval().result;
            m_store <= model_eval().store;
            m_waddr <= reg_waddr;
            m_wena  <= reg_wena;
            m_m2r   <= mem2reg;
            m_rena  <= mem_rena;
            m_mwena <= mem_wena;
            m_f3    <= funct3;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        e = model_eval();
        chk("flush",      {31'd0, pipelineFlush}, {31'd0, e.flush});
        chk("target_pc",  target_pc, e.target);
        chk("alu_result", exm.alu_result_o, m_alu);
        chk("store_data", exm.store_data_o, m_store);
        chk("reg_waddr",  {27'd0, exm.reg_waddr_o}, {27'd0, m_waddr});
        chk("ctrl",       {28'd0, exm.reg_wena_o, exm.mem2reg_o, exm.mem_rena_o, exm.mem_wena_o},
                          {28'd0, m_wena, m_m2r, m_rena, m_mwena});
        chk("funct3_o",   {29'd0, exm.funct3_o}, {29'd0, m_f3});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        rst = 1'b1; curr_pc = 0; reg1_data = 0; reg2_data = 0; imm = 0; wb_data = 0;
        reg1_raddr = 0; reg2_raddr = 0; reg_waddr = 0; wb_reg_waddr = 0;
        branch = 0; reg_wena = 0; mem2reg = 0; mem_rena = 0; mem_wena = 0;
        alusrc = 0; funct7 = 0; wb_reg_wena = 0; mem_stall = 0;
        aluop = 0; jump = 0; funct3 = 0;
    endtask

    task automatic rand_inputs();
        curr_pc      = $urandom & 32'hFFFF_FFFC;
        reg1_data    = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 8)) - 4) : $urandom;
        reg2_data    = ($urandom_range(0, 3) == 0) ? reg1_data : $urandom;
        imm          = ($urandom_range(0, 1) == 0) ? 32'(int'($urandom_range(0, 64)) - 32) : $urandom;
        wb_data      = $urandom;
        reg1_raddr   = 5'($urandom_range(0, 3));
        reg2_raddr   = 5'($urandom_range(0, 3));
        reg_waddr    = 5'($urandom_range(0, 3));
        wb_reg_waddr = 5'($urandom_range(0, 3));
        branch       = 1'($urandom);
        reg_wena     = 1'($urandom);
        mem2reg      = 1'($urandom);
        mem_rena     = 1'($urandom);
        mem_wena     = 1'($urandom);
        alusrc       = 1'($urandom);
        funct7       = 1'($urandom);
        wb_reg_wena  = 1'($urandom);
        aluop        = 2'($urandom);
        jump         = 2'($urandom);
        funct3       = 3'($urandom);
        mem_stall    = $urandom_range(0, 4) == 0;
    endtask

    initial begin
        bubble();
        rst = 1'b0;

        // Reset holds everything cleared regardless of inputs.
        rand_inputs();
        jump = 2'b01;
        #1 chk("rst_flush", {31'd0, pipelineFlush}, 32'd0);
        step();
        step();
        chk("rst_alu", exm.alu_result_o, 32'd0);
        chk("rst_wena", {31'd0, exm.reg_wena_o}, 32'd0);

        bubble();
        aluop = 2'b11; imm = 32'h55; reg_wena = 1; reg_waddr = 5'd2;
        step();
        chk("first_load", exm.alu_result_o, 32'h55);
        chk("first_waddr", {27'd0, exm.reg_waddr_o}, 32'd2);

        bubble();
        step();
        reg1_raddr = 1; reg2_raddr = 2; reg1_data = 5; reg2_data = 3;
        aluop = 2'b10; funct3 = 0; funct7 = 1; reg_wena = 1; reg_waddr = 5;
        step();
        chk("sub", exm.alu_result_o, 32'd2);
        alusrc = 1; imm = 3;
        step();
        chk("addi", exm.alu_result_o, 32'd8);

        bubble();
        aluop = 2'b11; imm = 32'h10; reg_wena = 1; reg_waddr = 1;
        step();
        bubble();
        wb_reg_wena = 1; wb_reg_waddr = 1; wb_data = 32'h20;
        reg1_raddr = 1; reg1_data = 32'h99; reg_wena = 1; reg_waddr = 0;
        step();
        chk("fwd_prio", exm.alu_result_o, 32'h10);
        chk("rd_x0", {27'd0, exm.reg_waddr_o}, 32'd0);
        bubble();
        wb_reg_wena = 1; wb_reg_waddr = 0; wb_data = 32'h20;
        step();
        chk("fwd_x0", exm.alu_result_o, 32'd0);

        bubble();
        reg1_raddr = 3; reg2_raddr = 4; reg1_data = 32'hFFFF_FFFF; reg2_data = 1;
        branch = 1; aluop = 2'b01; funct3 = 3'b100; curr_pc = 32'h100; imm = 32'h20;
        #1 chk("blt_flush", {31'd0, pipelineFlush}, 32'd1);
        chk("blt_target", target_pc, 32'h120);
        funct3 = 3'b110;
        #1 chk("bltu_flush", {31'd0, pipelineFlush}, 32'd0);
        chk("bltu_target", target_pc, 32'h104);
        step();

        bubble();
        jump = 2'b10; reg1_raddr = 3; reg1_data = 32'h203; imm = 4; curr_pc = 32'h40;
        alusrc = 1; reg_wena = 1; reg_waddr = 1;
        #1 chk("jalr_target", target_pc, 32'h206);
        step();
        chk("jalr_link", exm.alu_result_o, 32'h44);
        chk("jalr_wena", {31'd0, exm.reg_wena_o}, 32'd1);

        bubble();
        reg1_raddr = 5; reg2_raddr = 6; reg1_data = 7; reg2_data = 7;
        branch = 1; aluop = 2'b01; funct3 = 0; curr_pc = 32'h80; imm = 8; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_noflush", {31'd0, pipelineFlush}, 32'd0);
            step();
            chk("stall_hold", exm.alu_result_o, 32'h44);
        end
        mem_stall = 0;
        #1 chk("release_flush", {31'd0, pipelineFlush}, 32'd1);
        chk("release_target", target_pc, 32'h88);
        step();
        bubble();
        #1 chk("single_pulse", {31'd0, pipelineFlush}, 32'd0);
        chk("beq_result", exm.alu_result_o, 32'd0);

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst = $urandom_range(0, 49) != 0;
            step();
        end

        bubble();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I core. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Contains operand forwarding, the ALU, and branch/jump resolution (producing the pipeline flush and redirect target).
- Contains the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width; equals `instWidth.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- curr_pc  in  XLEN  PC of the instruction in EX
- reg1_data  in  XLEN  rs1 value read in ID
- reg2_data  in  XLEN  rs2 value read in ID
- imm  in  XLEN  sign-extended immediate
- reg1_raddr  in  5  rs1 index
- reg2_raddr  in  5  rs2 index
- reg_waddr  in  5  rd index
- branch  in  1  conditional branch
- reg_wena  in  1  rd write enable
- mem2reg  in  1  WB selects memory data
- mem_rena  in  1  load
- mem_wena  in  1  store
- aluop  in  2  00 add, 01 branch compare, 10 funct-decoded, 11 pass imm
- alusrc  in  1  0: operand B = rs2, 1: operand B = imm
- jump  in  2  00 none, 01 JAL, 10 JALR, 11 reserved (treated as none)
- funct3  in  3  instruction funct3
- funct7  in  1  instruction bit 30
- wb_reg_wena  in  1  MEM/WB write enable
- wb_reg_waddr  in  5  MEM/WB rd
- wb_data  in  XLEN  MEM/WB write-back value
- mem_stall  in  1  memory stage busy; hold EX/MEM
- pipelineFlush  out  1  taken branch/jump; flush IF/ID and ID/EX
- target_pc  out  XLEN  redirect address
- alu_result_o  out  XLEN  registered ALU / link result
- store_data_o  out  XLEN  registered forwarded rs2
- reg_waddr_o  out  5  registered rd
- reg_wena_o  out  1  registered
- mem2reg_o  out  1  registered
- mem_rena_o  out  1  registered
- mem_wena_o  out  1  registered
- funct3_o  out  3  registered; load/store size for MEM

Behaviour:
- Reset (rst=0, asynchronous): every registered output is cleared to 0. pipelineFlush=0 while rst=0. Reset mid-instruction discards the instruction with no write-back.
- Forwarding (combinational), evaluated per source operand:
  - Select EX/MEM alu_result_o if reg_wena_o=1, mem2reg_o=0, reg_waddr_o==raddr and raddr!=0.
  - Otherwise select wb_data if wb_reg_wena=1, wb_reg_waddr==raddr and raddr!=0.
  - Otherwise use the ID value.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
  - Load-use hazards are resolved upstream by a bubble.
- Operand B = imm when alusrc=1, else forwarded rs2.
- ALU:
  - aluop 00: A+B.
  - aluop 11: imm.
  - aluop 10, by funct3:
    - 000: ADD, or SUB when funct7=1 and alusrc=0.
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND.
    - 101: SRL, or SRA when funct7=1.
    - Shift amount is B[4:0].
  - aluop 01: result unused (0).
  - All arithmetic is modulo 2^32.
- Branch condition, by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Codes 010 and 011 mean not taken. Comparisons use the forwarded operands.
- Control transfer:
  - JAL: target = curr_pc+imm.
  - Taken branch: target = curr_pc+imm.
  - JALR: target = (fwd_rs1+imm) & ~1.
  - For JAL and JALR, the registered result = curr_pc+4.
  - When no transfer is taken, target_pc = curr_pc+4.
- pipelineFlush = (jump∈{01,10} | (branch & cond)) & !mem_stall. It is combinational in the same cycle the instruction is in EX. It is suppressed during a stall because the instruction is re-evaluated when the stall releases, giving exactly one flush pulse per taken transfer.
- EX/MEM register, on the rising edge:
  - mem_stall=1: all outputs hold.
  - Otherwise: all outputs load the current EX values. Latency is 1 cycle.
  - A bubble from ID/EX (reg_wena=mem_rena=mem_wena=branch=0, jump=00) propagates as a no-op.
- Simultaneous events:
  - Same-register forward from both EX/MEM and MEM/WB: EX/MEM wins.
  - Flush with mem_stall: no flush.
  - rd=x0 with reg_wena=1: registered unchanged. The register file ignores x0.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0, pipelineFlush=0. Release rst → first edge loads EX values.
- ADD then SUB: x1=5, x2=3, aluop=10, funct3=000, funct7=1, alusrc=0 → alu_result_o=2 after 1 cycle. Same inputs with alusrc=1 and imm=3 → 8.
- Forward priority: EX/MEM holds rd=x1=0x10 and MEM/WB holds rd=x1=0x20; next instruction is ADD x1+x0 → 0x10. Repeat with rs=x0 → 0.
- Branch: BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → pipelineFlush=1, target_pc=0x120. BLTU with the same operands → no flush, target 0x104.
- JALR: rs1=0x203, imm=4, pc=0x40 → target_pc=0x206, alu_result_o=0x44, reg_wena_o=1.
- Stall: mem_stall=1 for 3 cycles during a taken BEQ → outputs hold and pipelineFlush=0. When the stall releases → exactly one flush pulse.
